// File: rtl/conv2_seq_ctrl.sv
// Sequencer for the conv-layer-2 datapath: per filter set it loads the weights, streams the
// feature rows as spaced beats, counts results, closes the pass with pool_end and tags results.
module conv2_seq_ctrl #(
    parameter int IMG_ROWS = 12,
    parameter int N_FILT   = 8,
    parameter int FM_AW    = 8,
    parameter int TIMEOUT  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [FM_AW-1:0] fm_base,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             fm_rd_en,
    output logic [FM_AW-1:0] fm_addr,
    input  logic [383:0]     fm_rdata,
    output logic             wgt_rd_en,
    output logic [2:0]       wgt_addr,
    input  logic [143:0]     wgt_rdata,
    output logic             en,
    output logic             din_valid,
    output logic             pool_end,
    output logic [95:0]      data_in_0,
    output logic [95:0]      data_in_1,
    output logic [95:0]      data_in_2,
    output logic [95:0]      data_in_3,
    output logic [47:0]      Filtr_in_0,
    output logic [47:0]      Filtr_in_1,
    output logic [47:0]      Filtr_in_2,
    input  logic             dout_vald,
    input  logic [95:0]      Psum_d_out,
    output logic             out_valid,
    output logic [95:0]      out_psum,
    output logic [2:0]       out_filt,
    output logic [3:0]       out_row
);
    localparam int RW = $clog2(IMG_ROWS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_ROWS - 1);
    localparam logic [RW-1:0] K_FULL   = RW'(IMG_ROWS - 2);
    localparam logic [RW-1:0] K_SAT    = RW'(IMG_ROWS - 3);
    localparam logic [2:0]    LAST_F   = 3'(N_FILT - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_FEED, S_DRAIN, S_POOL, S_DONE} state_t;

    state_t           state_q, state_d;
    logic             ph_q, ph_d;
    logic [2:0]       f_q, f_d;
    logic [RW-1:0]    r_q, r_d;
    logic [RW-1:0]    k_q, k_d;
    logic [TW-1:0]    idle_q, idle_d;
    logic [FM_AW-1:0] base_q, base_d;
    logic             err_q, err_d;
    logic             load_w, load_row;

    logic [3:0][95:0] row_q;
    logic [2:0][47:0] filt_q;
    logic             din_valid_q, out_valid_q;
    logic [95:0]      out_psum_q;
    logic [2:0]       out_filt_q;
    logic [3:0]       out_row_q;

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        f_d       = f_q;
        r_d       = r_q;
        k_d       = k_q;
        idle_d    = idle_q;
        base_d    = base_q;
        err_d     = err_q;
        wgt_rd_en = 1'b0;
        fm_rd_en  = 1'b0;
        pool_end  = 1'b0;
        done      = 1'b0;
        load_w    = 1'b0;
        load_row  = 1'b0;

        // Results beyond the expected count of a pass are tagged but not counted.
        if (dout_vald && k_q != K_FULL &&
            (state_q == S_LOAD_W || state_q == S_FEED || state_q == S_DRAIN)) begin
            k_d = k_q + RW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = fm_base;
                    f_d     = 3'd0;
                    r_d     = '0;
                    k_d     = '0;
                    ph_d    = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                if (!ph_q) begin
                    wgt_rd_en = 1'b1;
                    ph_d      = 1'b1;
                end else begin
                    load_w  = 1'b1;
                    ph_d    = 1'b0;
                    r_d     = '0;
                    state_d = S_FEED;
                end
            end
            S_FEED: begin
                if (!ph_q) begin
                    fm_rd_en = 1'b1;
                    ph_d     = 1'b1;
                end else begin
                    load_row = 1'b1;
                    ph_d     = 1'b0;
                    if (r_q == LAST_ROW) begin
                        idle_d  = '0;
                        state_d = S_DRAIN;
                    end else begin
                        r_d = r_q + RW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (k_q == K_FULL) begin
                    state_d = S_POOL;
                end else if (dout_vald) begin
                    idle_d = '0;
                end else if (idle_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    idle_d = idle_q + TW'(1);
                end
            end
            S_POOL: begin
                pool_end = 1'b1;
                k_d      = '0;
                if (f_q == LAST_F) begin
                    state_d = S_DONE;
                end else begin
                    f_d     = f_q + 3'd1;
                    state_d = S_LOAD_W;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ph_q        <= 1'b0;
            f_q         <= 3'd0;
            r_q         <= '0;
            k_q         <= '0;
            idle_q      <= '0;
            base_q      <= '0;
            err_q       <= 1'b0;
            row_q       <= '0;
            filt_q      <= '0;
            din_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_psum_q  <= '0;
            out_filt_q  <= 3'd0;
            out_row_q   <= 4'd0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            f_q         <= f_d;
            r_q         <= r_d;
            k_q         <= k_d;
            idle_q      <= idle_d;
            base_q      <= base_d;
            err_q       <= err_d;
            din_valid_q <= load_row;
            out_valid_q <= dout_vald;
            for (int i = 0; i < 3; i++) begin
                if (load_w) filt_q[i] <= wgt_rdata[i*48 +: 48];
            end
            for (int i = 0; i < 4; i++) begin
                if (load_row) row_q[i] <= fm_rdata[i*96 +: 96];
            end
            if (dout_vald) begin
                out_psum_q <= Psum_d_out;
                out_filt_q <= f_q;
                out_row_q  <= 4'((k_q >= K_FULL) ? K_SAT : k_q);
            end
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign en         = busy;
    assign err        = err_q;
    assign fm_addr    = fm_rd_en ? (base_q + FM_AW'(r_q)) : '0;
    assign wgt_addr   = wgt_rd_en ? f_q : 3'd0;
    assign din_valid  = din_valid_q;
    assign data_in_0  = row_q[0];
    assign data_in_1  = row_q[1];
    assign data_in_2  = row_q[2];
    assign data_in_3  = row_q[3];
    assign Filtr_in_0 = filt_q[0];
    assign Filtr_in_1 = filt_q[1];
    assign Filtr_in_2 = filt_q[2];
    assign out_valid  = out_valid_q;
    assign out_psum   = out_psum_q;
    assign out_filt   = out_filt_q;
    assign out_row    = out_row_q;

endmodule

// File: tb/tb_conv2_seq_ctrl.sv
// Directed bench for conv2_seq_ctrl: memory and 3-cycle datapath models, event logs,
// immediate-assertion checks on runs, wrap-around, timeout, busy-start and mid-run reset.
module tb_conv2_seq_ctrl;
    localparam int IMG_ROWS = 4;
    localparam int N_FILT   = 8;
    localparam int TIMEOUT  = 16;

    logic         clk, rst_n, start;
    logic [7:0]   fm_base;
    logic         busy, done, err, fm_rd_en, wgt_rd_en, en, din_valid, pool_end;
    logic [7:0]   fm_addr;
    logic [383:0] fm_rdata;
    logic [2:0]   wgt_addr;
    logic [143:0] wgt_rdata;
    logic [95:0]  data_in_0, data_in_1, data_in_2, data_in_3;
    logic [47:0]  Filtr_in_0, Filtr_in_1, Filtr_in_2;
    logic         dout_vald;
    logic [95:0]  Psum_d_out;
    logic         out_valid;
    logic [95:0]  out_psum;
    logic [2:0]   out_filt;
    logic [3:0]   out_row;

    conv2_seq_ctrl #(.IMG_ROWS(IMG_ROWS), .N_FILT(N_FILT), .FM_AW(8), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .fm_base(fm_base),
        .busy(busy), .done(done), .err(err),
        .fm_rd_en(fm_rd_en), .fm_addr(fm_addr), .fm_rdata(fm_rdata),
        .wgt_rd_en(wgt_rd_en), .wgt_addr(wgt_addr), .wgt_rdata(wgt_rdata),
        .en(en), .din_valid(din_valid), .pool_end(pool_end),
        .data_in_0(data_in_0), .data_in_1(data_in_1), .data_in_2(data_in_2), .data_in_3(data_in_3),
        .Filtr_in_0(Filtr_in_0), .Filtr_in_1(Filtr_in_1), .Filtr_in_2(Filtr_in_2),
        .dout_vald(dout_vald), .Psum_d_out(Psum_d_out),
        .out_valid(out_valid), .out_psum(out_psum), .out_filt(out_filt), .out_row(out_row)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memories: each row/filter word carries its own index plus the read address.
    always @(posedge clk) begin
        if (fm_rd_en)
            fm_rdata <= {80'd0, 4'd4, 4'd0, fm_addr, 80'd0, 4'd3, 4'd0, fm_addr,
                         80'd0, 4'd2, 4'd0, fm_addr, 80'd0, 4'd1, 4'd0, fm_addr};
        if (wgt_rd_en)
            wgt_rdata <= {40'd0, 4'd3, 1'b0, wgt_addr, 40'd0, 4'd2, 1'b0, wgt_addr,
                          40'd0, 4'd1, 1'b0, wgt_addr};
    end

    // Datapath model: beats 2.. of a pass echo a result 3 cycles after din_valid.
    logic        silent;
    logic [2:0]  dv_sr;
    logic [95:0] psum_sr [3];
    int          beat;
    always @(posedge clk) begin
        if (!rst_n) begin
            dv_sr <= 3'b000;
            beat  <= 0;
        end else begin
            dv_sr      <= {dv_sr[1:0], din_valid && beat >= 2 && !silent};
            psum_sr[0] <= {data_in_3[15:0], data_in_2[15:0], data_in_1[15:0], data_in_0[15:0],
                           8'd0, Filtr_in_2[7:0], Filtr_in_1[7:0], Filtr_in_0[7:0]};
            psum_sr[1] <= psum_sr[0];
            psum_sr[2] <= psum_sr[1];
            if (pool_end || !busy) beat <= 0;
            else if (din_valid)    beat <= beat + 1;
        end
    end
    assign dout_vald  = dv_sr[2];
    assign Psum_d_out = psum_sr[2];

    // Event logs sampled on the falling edge.
    logic [7:0]   fm_log[$];
    logic [2:0]   wgt_log[$];
    logic [102:0] tag_log[$];
    int dv_cnt = 0, pool_cnt = 0, done_cnt = 0, b2b_cnt = 0;
    logic prev_dv = 1'b0;
    always @(negedge clk) begin
        if (din_valid) dv_cnt++;
        if (din_valid && prev_dv) b2b_cnt++;
        prev_dv = din_valid;
        if (pool_end) pool_cnt++;
        if (done) done_cnt++;
        if (fm_rd_en) fm_log.push_back(fm_addr);
        if (wgt_rd_en) wgt_log.push_back(wgt_addr);
        if (out_valid) tag_log.push_back({out_filt, out_row, out_psum});
    end

    int checks = 0, failures = 0;
    int fm_i0, wg_i0, tg_i0, dv0, pl0, dn0, b2b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] exp_psum(input logic [7:0] a, input logic [2:0] f);
        return {4'd4, 4'd0, a, 4'd3, 4'd0, a, 4'd2, 4'd0, a, 4'd1, 4'd0, a,
                8'd0, 4'd3, 1'b0, f, 4'd2, 1'b0, f, 4'd1, 1'b0, f};
    endfunction

    task automatic snapshot();
        fm_i0 = fm_log.size();  wg_i0 = wgt_log.size(); tg_i0 = tag_log.size();
        dv0 = dv_cnt; pl0 = pool_cnt; dn0 = done_cnt; b2b0 = b2b_cnt;
    endtask

    task automatic pulse_start(input logic [7:0] base);
        start = 1'b1; fm_base = base;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic seen = 1'b0;
        for (int n = 0; n < 1000 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, 128'(seen), 128'd1);
        @(negedge clk);
        chk({tag, "_idle_after_done"}, {busy, en, done}, 3'b000);
    endtask

    task automatic check_run(input string tag, input logic [7:0] base);
        chk({tag, "_done_pulses"}, done_cnt - dn0, 1);
        chk({tag, "_pool_pulses"}, pool_cnt - pl0, N_FILT);
        chk({tag, "_din_beats"}, dv_cnt - dv0, N_FILT * IMG_ROWS);
        chk({tag, "_din_b2b"}, b2b_cnt - b2b0, 0);
        chk({tag, "_wgt_reads"}, wgt_log.size() - wg_i0, N_FILT);
        for (int j = 0; j < N_FILT; j++)
            chk($sformatf("%s_wgt_addr%0d", tag, j), 128'(wgt_log[wg_i0 + j]), 128'(j));
        chk({tag, "_fm_reads"}, fm_log.size() - fm_i0, N_FILT * IMG_ROWS);
        for (int j = 0; j < N_FILT * IMG_ROWS; j++) begin
            automatic logic [7:0] ea = base + 8'(j % IMG_ROWS);
            chk($sformatf("%s_fm_addr%0d", tag, j), 128'(fm_log[fm_i0 + j]), 128'(ea));
        end
        chk({tag, "_tags"}, tag_log.size() - tg_i0, N_FILT * (IMG_ROWS - 2));
        for (int j = 0; j < N_FILT * (IMG_ROWS - 2); j++) begin
            automatic logic [2:0] ef = 3'(j / (IMG_ROWS - 2));
            automatic logic [3:0] ek = 4'(j % (IMG_ROWS - 2));
            automatic logic [7:0] ea = base + 8'(ek) + 8'd2;
            chk($sformatf("%s_tag%0d", tag, j), 128'(tag_log[tg_i0 + j]),
                128'({ef, ek, exp_psum(ea, ef)}));
        end
        $display("run %s base=%02h: checks=%0d failures=%0d", tag, base, checks, failures);
    endtask

    initial begin
        int lat, last_dv, err_n;
        rst_n = 1'b0; start = 1'b0; fm_base = 8'h00; silent = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {busy, en, done, err, fm_rd_en, wgt_rd_en, din_valid, pool_end, out_valid},
            9'd0);
        chk("reset_addr", {fm_addr, wgt_addr}, 11'd0);
        chk("reset_data", {data_in_0, Filtr_in_0, out_psum}, 240'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Run A: latency, full 8-filter run, start ignored while busy.
        snapshot();
        start = 1'b1; fm_base = 8'h10; lat = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0;
                chk("A_busy_en_after_start", {busy, en}, 2'b11);
            end
            if (din_valid && lat == 0) lat = n;
        end
        chk("A_start_to_din_valid", lat, 5);
        pulse_start(8'h80);
        wait_done("A");
        check_run("A", 8'h10);

        // Run B: address wrap FE,FF,00,01.
        snapshot();
        pulse_start(8'hFE);
        wait_done("B");
        check_run("B", 8'hFE);

        // Run C: silent datapath -> timeout after TIMEOUT idle DRAIN cycles.
        snapshot();
        silent = 1'b1; last_dv = 0; err_n = 0;
        start = 1'b1; fm_base = 8'h20;
        for (int n = 1; n <= 300 && err_n == 0; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (din_valid) last_dv = n;
            if (err) err_n = n;
        end
        chk("C_err_seen", 128'(err_n != 0), 128'd1);
        chk("C_timeout_cycles", err_n - last_dv, TIMEOUT);
        chk("C_idle_after_err", {busy, en, err}, 3'b001);
        chk("C_no_done_pool", {done_cnt - dn0, pool_cnt - pl0}, 64'd0);
        chk("C_din_beats", dv_cnt - dv0, IMG_ROWS);
        $display("run C timeout: err after %0d cycles", err_n - last_dv);

        // Run D: start after err clears it and completes normally.
        silent = 1'b0;
        @(negedge clk);
        snapshot();
        pulse_start(8'h30);
        chk("D_err_cleared", {err, busy}, 2'b01);
        wait_done("D");
        check_run("D", 8'h30);

        // Reset asserted mid-FEED after the first beat, then a clean restart.
        start = 1'b1; fm_base = 8'h40;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
        end
        chk("R_first_beat_live", {din_valid, busy}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("R_ctrl_zero", {busy, en, done, err, fm_rd_en, wgt_rd_en, din_valid, pool_end, out_valid},
            9'd0);
        chk("R_data_zero", {data_in_0, data_in_3, Filtr_in_0, Filtr_in_2}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        snapshot();
        pulse_start(8'h50);
        wait_done("E");
        check_run("E", 8'h50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
